// File: rtl/kernel_key_pio.sv
// rtl/kernel_key_pio.sv - Avalon-MM push-button input port with debounce, edge capture and irq
// Inputs are synchronised, debounced per bit, and edges latched into W1C sticky bits.
module kernel_key_pio #(
  parameter int               WIDTH        = 4,
  parameter int               DEBOUNCE_CYC = 50000,
  parameter int               EDGE_TYPE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise, fall, edge_set, edge_clr;
  logic             unused_wdata;

  // Upper writedata bits are deliberately ignored when WIDTH < 32.
  assign unused_wdata = ^writedata;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // A level is accepted only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stable_prev_d = stable_q;
    rise          = stable_q & ~stable_prev_q;
    fall          = ~stable_q & stable_prev_q;
    if (EDGE_TYPE == 0) begin
      edge_set = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_set = fall;
    end else begin
      edge_set = rise | fall;
    end
    wr_en    = chipselect && !write_n;
    edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // Set is applied after clear so a coincident new edge is never lost.
    edge_d   = (edge_q & ~edge_clr) | edge_set;
    mask_d   = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(edge_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= RESET_VALUE;
      sync2_q       <= RESET_VALUE;
      stable_q      <= RESET_VALUE;
      stable_prev_q <= RESET_VALUE;
      mask_q        <= '0;
      edge_q        <= '0;
      readdata_q    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      readdata_q    <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_kernel_key_pio.sv
// tb/tb_kernel_key_pio.sv - self-checking bench for kernel_key_pio
// Directed scenarios plus random bus/button traffic against a sample-window reference model.
module tb_kernel_key_pio;

  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  cur_in = 4'hF;
  logic [3:0]  st_m, prev_m, edge_m, mask_m;
  logic [31:0] rd_m;
  logic        irq_m;
  logic [3:0]  samp[$];

  kernel_key_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYC(DC),
    .EDGE_TYPE(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pre-reset history counts as the pulled-up level.
  task automatic model_reset();
    st_m   = 4'hF;
    prev_m = 4'hF;
    edge_m = 4'h0;
    mask_m = 4'h0;
    rd_m   = 32'h0;
    irq_m  = 1'b0;
    samp.delete();
    repeat (DC + 2) samp.push_back(4'hF);
  endtask

  // A bit takes a new level once the DC samples taken 2..DC+1 edges ago all show it.
  task automatic model_step(input logic [1:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [3:0] ip);
    logic [3:0] st_n, clr, s;
    logic       all_new;
    case (a)
      2'd0:    rd_m = {28'h0, st_m};
      2'd2:    rd_m = {28'h0, mask_m};
      2'd3:    rd_m = {28'h0, edge_m};
      default: rd_m = 32'h0;
    endcase
    for (int b = 0; b < 4; b++) begin
      all_new = 1'b1;
      for (int j = 0; j < DC; j++) begin
        s = samp[samp.size() - 2 - j];
        if (s[b] == st_m[b]) all_new = 1'b0;
      end
      st_n[b] = all_new ? ~st_m[b] : st_m[b];
    end
    clr    = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
    edge_m = (edge_m & ~clr) | (~st_m & prev_m);
    if (cs && !wn && a == 2'd2) mask_m = wd[3:0];
    prev_m = st_m;
    st_m   = st_n;
    samp.push_back(ip);
    void'(samp.pop_front());
    irq_m  = |(edge_m & mask_m);
  endtask

  task automatic tick(input logic [1:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [3:0] ip);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = ip;
    cur_in     = ip;
    @(posedge clk);
    model_step(a, cs, wn, wd, ip);
    #1;
    check("rdata", readdata, rd_m);
    check("irq", {31'h0, irq}, {31'h0, irq_m});
  endtask

  task automatic hold(input int n, input logic [3:0] ip);
    for (int i = 0; i < n; i++) tick(2'd0, 1'b0, 1'b1, 32'h0, ip);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    tick(a, 1'b1, 1'b1, 32'h0, cur_in);
    v = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(a, 1'b1, 1'b0, d, cur_in);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    in_port    = 4'hF;
    cur_in     = 4'hF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    model_reset();
    #1;
    check("rst_rdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    do_reset();

    rd(2'd0, v);
    check("t1_data", v, 32'hF);
    rd(2'd3, v);
    check("t1_edge", v, 32'h0);

    hold(7, 4'hE);
    hold(14, 4'hF);
    rd(2'd0, v);
    check("t2_glitch_data", v, 32'hF);
    rd(2'd3, v);
    check("t2_glitch_edge", v, 32'h0);

    wr(2'd2, 32'h1);
    for (int i = 1; i <= 11; i++) begin
      tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hE);
      check("t2_latency", readdata, (i >= 11) ? 32'hE : 32'hF);
    end

    check("t3_irq_set", {31'h0, irq}, 32'h1);
    rd(2'd3, v);
    check("t3_edge", v, 32'h1);
    wr(2'd3, 32'h1);
    check("t3_irq_clr", {31'h0, irq}, 32'h0);
    rd(2'd3, v);
    check("t3_edge_clr", v, 32'h0);

    wr(2'd2, 32'h0);
    hold(12, 4'hB);
    rd(2'd3, v);
    check("t4_edge", v, 32'h4);
    check("t4_irq_masked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'hFFFF_FFF4);
    check("t4_irq_unmask", {31'h0, irq}, 32'h1);
    rd(2'd2, v);
    rd(2'd2, v);
    check("t4_mask_width", v, 32'h4);

    wr(2'd3, 32'hF);
    hold(10, 4'h9);
    tick(2'd3, 1'b1, 1'b0, 32'h2, 4'h9);
    rd(2'd3, v);
    check("t5_set_wins", v, 32'h2);

    hold(3, 4'hF);
    hold(4, 4'h7);
    do_reset();
    hold(20, 4'hF);
    rd(2'd3, v);
    check("t6_edge", v, 32'h0);
    rd(2'd0, v);
    check("t6_data", v, 32'hF);
    rd(2'd2, v);
    check("t6_mask", v, 32'h0);

    for (int c = 0; c < 800; c++) begin
      logic [3:0] ip;
      ip = cur_in;
      if ($urandom_range(11) == 0) ip = 4'($urandom);
      if (c == 400) begin
        do_reset();
      end else begin
        tick(2'($urandom), 1'($urandom_range(1)), ($urandom_range(3) != 0), $urandom, ip);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
